// File: rtl/min_path_selector.sv
// Survivor selector: registered pairwise min-metric tree over NUM_STATES {metric, path, index} candidates.
// Latency LVL = log2(NUM_STATES) cycles, one beat per cycle; ties go to the lowest state index.
// Backpressure: the whole tree stalls while valid_out && !ready_out; refresh flushes regardless of stall.
module min_path_selector #(
  parameter int NUM_STATES = 4,
  parameter int METRIC_W   = 4,
  parameter int PATH_W     = 8,
  parameter int PTR_W      = 3,
  localparam int LVL       = $clog2(NUM_STATES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         refresh,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic [NUM_STATES*PATH_W-1:0]   path_in,
  input  logic [NUM_STATES*METRIC_W-1:0] metric_in,
  input  logic [PTR_W-1:0]             write_pointer_in,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic [PATH_W-1:0]            out,
  output logic [LVL-1:0]               out_state,
  output logic [METRIC_W-1:0]          out_metric,
  output logic [PTR_W-1:0]             write_pointer_out,
  output logic                         renorm_req
);

  localparam int NODES = NUM_STATES - 1;

  typedef struct packed {
    logic [METRIC_W-1:0] metric;
    logic [PATH_W-1:0]   path;
    logic [LVL-1:0]      idx;
  } cand_t;

  localparam cand_t RST_CAND = cand_t'({{METRIC_W{1'b1}}, {(PATH_W + LVL){1'b0}}});

  cand_t            node_q [NODES];
  cand_t            node_d [NODES];
  logic [LVL-1:0]   vld_q;
  logic [PTR_W-1:0] ptr_q [LVL];
  logic             advance;
  logic             accept;

  function automatic cand_t pick(input cand_t a, input cand_t b);
    return (a.metric <= b.metric) ? a : b;
  endfunction

  assign valid_out = vld_q[LVL-1];
  assign advance   = !valid_out || ready_out;
  assign ready_in  = advance && !refresh;
  assign accept    = valid_in && ready_in;

  // Nodes are stored flat: level k starts at NUM_STATES - (NUM_STATES >> k), so the last node is the output.
  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int CUR = NUM_STATES - (NUM_STATES >> k);
    for (genvar j = 0; j < (NUM_STATES >> (k + 1)); j++) begin : g_node
      if (k == 0) begin : g_leaf
        cand_t a;
        cand_t b;
        assign a = cand_t'({metric_in[(2*j)*METRIC_W +: METRIC_W],
                            path_in[(2*j)*PATH_W +: PATH_W], LVL'(2*j)});
        assign b = cand_t'({metric_in[(2*j+1)*METRIC_W +: METRIC_W],
                            path_in[(2*j+1)*PATH_W +: PATH_W], LVL'(2*j+1)});
        assign node_d[CUR + j] = pick(a, b);
      end else begin : g_inner
        localparam int PRV = NUM_STATES - (NUM_STATES >> (k - 1));
        assign node_d[CUR + j] = pick(node_q[PRV + 2*j], node_q[PRV + 2*j + 1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < NODES; i++) node_q[i] <= RST_CAND;
      for (int k = 0; k < LVL; k++) ptr_q[k] <= '0;
    end else if (refresh) begin
      vld_q <= '0;
      for (int i = 0; i < NODES; i++) node_q[i] <= RST_CAND;
      for (int k = 0; k < LVL; k++) ptr_q[k] <= '0;
    end else if (advance) begin
      // Bubbles still load data; only the valid bit marks the slot as empty.
      vld_q[0] <= accept;
      ptr_q[0] <= write_pointer_in;
      for (int k = 1; k < LVL; k++) begin
        vld_q[k] <= vld_q[k-1];
        ptr_q[k] <= ptr_q[k-1];
      end
      for (int i = 0; i < NODES; i++) node_q[i] <= node_d[i];
    end
  end

  assign out               = node_q[NODES-1].path;
  assign out_state         = node_q[NODES-1].idx;
  assign out_metric        = node_q[NODES-1].metric;
  assign write_pointer_out = ptr_q[LVL-1];
  assign renorm_req        = out_metric[METRIC_W-1];

endmodule

// File: tb/tb_min_path_selector.sv
// Bench for min_path_selector: table-driven beats plus a scoreboard queue for the 4-state
// instance, and a hand-written sequence for an 8-state instance.
module tb_min_path_selector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-state instance
  logic        rst_n, refresh, valid_in, ready_in, valid_out, ready_out, renorm_req;
  logic [31:0] path_in;
  logic [15:0] metric_in;
  logic [2:0]  write_pointer_in, write_pointer_out;
  logic [7:0]  out;
  logic [1:0]  out_state;
  logic [3:0]  out_metric;

  // 8-state instance
  logic        refresh8, valid_in8, ready_in8, valid_out8, ready_out8, renorm_req8;
  logic [63:0] path_in8;
  logic [47:0] metric_in8;
  logic [2:0]  ptr_in8, ptr_out8;
  logic [7:0]  out8;
  logic [2:0]  out_state8;
  logic [5:0]  out_metric8;

  min_path_selector #(.NUM_STATES(4), .METRIC_W(4), .PATH_W(8), .PTR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .refresh(refresh), .valid_in(valid_in), .ready_in(ready_in),
    .path_in(path_in), .metric_in(metric_in), .write_pointer_in(write_pointer_in),
    .valid_out(valid_out), .ready_out(ready_out), .out(out), .out_state(out_state),
    .out_metric(out_metric), .write_pointer_out(write_pointer_out), .renorm_req(renorm_req)
  );

  min_path_selector #(.NUM_STATES(8), .METRIC_W(6), .PATH_W(8), .PTR_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .refresh(refresh8), .valid_in(valid_in8), .ready_in(ready_in8),
    .path_in(path_in8), .metric_in(metric_in8), .write_pointer_in(ptr_in8),
    .valid_out(valid_out8), .ready_out(ready_out8), .out(out8), .out_state(out_state8),
    .out_metric(out_metric8), .write_pointer_out(ptr_out8), .renorm_req(renorm_req8)
  );

  typedef struct packed {
    logic [7:0] path;
    logic [1:0] st;
    logic [3:0] metric;
    logic [2:0] ptr;
    logic       renorm;
  } exp_t;

  typedef struct packed {
    logic [3:0][3:0] m;
    logic [3:0][7:0] p;
    logic [2:0]      ptr;
    logic [1:0]      st;
    logic            rn;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t cur_exp;
  exp_t mon_e;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [15:0] m, input logic [31:0] p, input logic [2:0] ptr,
                               input logic [1:0] st, input logic rn);
    vec_t v;
    v.m = m; v.p = p; v.ptr = ptr; v.st = st; v.rn = rn;
    return v;
  endfunction

  function automatic exp_t tbl_exp(input vec_t v);
    exp_t e;
    e.st = v.st; e.path = v.p[v.st]; e.metric = v.m[v.st]; e.ptr = v.ptr; e.renorm = v.rn;
    return e;
  endfunction

  // Linear scan with strict '<' so the earliest state keeps ties.
  function automatic exp_t model(input logic [15:0] m, input logic [31:0] p, input logic [2:0] ptr);
    exp_t e;
    int   best = 0;
    for (int s = 1; s < 4; s++)
      if (m[s*4 +: 4] < m[best*4 +: 4]) best = s;
    e.st = 2'(best); e.metric = m[best*4 +: 4]; e.path = p[best*8 +: 8];
    e.ptr = ptr; e.renorm = e.metric[3];
    return e;
  endfunction

  // Scoreboard: push on acceptance, pop and compare on output transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (valid_out && ready_out) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got state %0d path %0h, expected no beat", out_state, out);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_path", out, mon_e.path);
          chk("sb_state", out_state, mon_e.st);
          chk("sb_metric", out_metric, mon_e.metric);
          chk("sb_ptr", write_pointer_out, mon_e.ptr);
          chk("sb_renorm", renorm_req, mon_e.renorm);
        end
      end
      if (refresh) sb.delete();
      else if (valid_in && ready_in) sb.push_back(cur_exp);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] m, input logic [31:0] p, input logic [2:0] ptr, input exp_t e);
    logic acc = 1'b0;
    metric_in = m; path_in = p; write_pointer_in = ptr; cur_exp = e; valid_in = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid_out"}, valid_out, 0);
    chk({tag, "_out"}, out, 8'h00);
    chk({tag, "_state"}, out_state, 0);
    chk({tag, "_metric"}, out_metric, 4'hF);
    chk({tag, "_ptr"}, write_pointer_out, 0);
    chk({tag, "_renorm"}, renorm_req, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] bm [3];
    logic [31:0] bp [3];
    exp_t        bx [3];
    logic [15:0] rm;
    logic [31:0] rp;

    tbl[0] = mkv({4'd9, 4'd7, 4'd5, 4'd1}, {8'hD0, 8'hC0, 8'hB0, 8'hA0}, 3'd3, 2'd0, 1'b0);
    tbl[1] = mkv({4'd7, 4'd6, 4'd2, 4'd8}, {8'h14, 8'h13, 8'h12, 8'h11}, 3'd4, 2'd1, 1'b0);
    tbl[2] = mkv({4'd7, 4'd3, 4'd8, 4'd9}, {8'h24, 8'h23, 8'h22, 8'h21}, 3'd5, 2'd2, 1'b0);
    tbl[3] = mkv({4'd4, 4'd7, 4'd8, 4'd9}, {8'h34, 8'h33, 8'h32, 8'h31}, 3'd6, 2'd3, 1'b0);
    tbl[4] = mkv({4'd5, 4'd5, 4'd5, 4'd5}, {8'h44, 8'h43, 8'h42, 8'h41}, 3'd7, 2'd0, 1'b0);
    tbl[5] = mkv({4'hF, 4'hF, 4'hF, 4'h0}, {8'h54, 8'h53, 8'h52, 8'h51}, 3'd0, 2'd0, 1'b0);
    tbl[6] = mkv({4'hC, 4'hB, 4'hA, 4'h9}, {8'h64, 8'h63, 8'h62, 8'h61}, 3'd1, 2'd0, 1'b1);
    // Row 5 stores metrics s3..s0 as {F,F,F,0} reversed order: fix so state 3 holds the zero.
    tbl[5] = mkv({4'h0, 4'hF, 4'hF, 4'hF}, {8'h54, 8'h53, 8'h52, 8'h51}, 3'd0, 2'd3, 1'b0);

    rst_n = 1'b0; refresh = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    path_in = '0; metric_in = '0; write_pointer_in = '0; cur_exp = '0;
    refresh8 = 1'b0; valid_in8 = 1'b0; ready_out8 = 1'b1;
    path_in8 = '0; metric_in8 = '0; ptr_in8 = '0;

    #12;
    chk_reset_outputs("rst");
    chk("rst8_valid_out", valid_out8, 0);
    chk("rst8_metric", out_metric8, 6'h3F);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: minimum at state 0, two-cycle latency
    send(tbl[0].m, tbl[0].p, tbl[0].ptr, tbl_exp(tbl[0]));
    @(negedge clk); chk("t1_lat_cycle1", valid_out, 0);
    @(negedge clk); chk("t1_lat_cycle2", valid_out, 1);
    idle(3);
    chk("t1_drain", sb.size(), 0);

    // 2: back-to-back beats, tie-break, renorm flag
    for (int i = 1; i < 7; i++) send(tbl[i].m, tbl[i].p, tbl[i].ptr, tbl_exp(tbl[i]));
    idle(5);
    chk("t2_drain", sb.size(), 0);

    // 3: backpressure for 4 cycles while 3 beats are offered
    for (int i = 0; i < 3; i++) begin
      bm[i] = 16'($urandom);
      bp[i] = $urandom;
      bx[i] = model(bm[i], bp[i], 3'(i + 2));
    end
    ready_out = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) send(bm[i], bp[i], 3'(i + 2), bx[i]);
      end
      begin
        repeat (2) @(negedge clk);
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          chk("t3_hold_valid", valid_out, 1);
          chk("t3_hold_path", out, bx[0].path);
          chk("t3_hold_state", out_state, bx[0].st);
          chk("t3_ready_in_low", ready_in, 0);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
      end
    join
    idle(6);
    chk("t3_drain", sb.size(), 0);

    // 4: refresh with one beat in flight and a beat offered in the same cycle
    rm = 16'($urandom); rp = $urandom;
    send(rm, rp, 3'd5, model(rm, rp, 3'd5));
    refresh = 1'b1; valid_in = 1'b1;
    metric_in = 16'h1234; path_in = 32'hDEADBEEF; write_pointer_in = 3'd7;
    cur_exp = model(16'h1234, 32'hDEADBEEF, 3'd7);
    @(negedge clk); chk("t4_ready_in_refresh", ready_in, 0);
    @(posedge clk); #1;
    refresh = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t4");
    idle(5);
    chk("t4_no_leak", sb.size(), 0);

    // 5: asynchronous reset with a full pipeline
    rm = 16'($urandom); rp = $urandom;
    send(rm, rp, 3'd1, model(rm, rp, 3'd1));
    rm = 16'($urandom); rp = $urandom;
    send(rm, rp, 3'd2, model(rm, rp, 3'd2));
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("t5");
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    send(16'h3592, 32'h44332211, 3'd4, model(16'h3592, 32'h44332211, 3'd4));
    @(negedge clk); chk("t5_lat_cycle1", valid_out, 0);
    @(negedge clk); chk("t5_lat_cycle2", valid_out, 1);
    idle(3);
    chk("t5_drain", sb.size(), 0);

    // 6: eight states, unique minimum at state 5, then all equal
    metric_in8 = {6'd63, 6'd40, 6'd3, 6'd9, 6'd7, 6'd33, 6'd20, 6'd10};
    path_in8   = {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    ptr_in8    = 3'd6;
    valid_in8  = 1'b1;
    @(negedge clk); chk("t6_ready_in", ready_in8, 1);
    @(posedge clk); #1;
    metric_in8 = {8{6'd12}};
    path_in8   = {8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h20};
    ptr_in8    = 3'd2;
    @(negedge clk); chk("t6_lat_cycle1", valid_out8, 0);
    @(posedge clk); #1;
    valid_in8 = 1'b0;
    @(negedge clk); chk("t6_lat_cycle2", valid_out8, 0);
    @(negedge clk);
    chk("t6_valid", valid_out8, 1);
    chk("t6_state", out_state8, 5);
    chk("t6_path", out8, 8'h15);
    chk("t6_metric", out_metric8, 6'd3);
    chk("t6_ptr", ptr_out8, 3'd6);
    @(negedge clk);
    chk("t6_eq_valid", valid_out8, 1);
    chk("t6_eq_state", out_state8, 0);
    chk("t6_eq_path", out8, 8'h20);
    chk("t6_eq_metric", out_metric8, 6'd12);
    chk("t6_eq_ptr", ptr_out8, 3'd2);
    @(negedge clk); chk("t6_empty", valid_out8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/min_path_selector.md
# min_path_selector

Parametrised survivor selector for the Viterbi decoder datapath. It takes one metric and one survivor path per trellis state and finds the state with the smallest accumulated metric through a registered pairwise-comparison tree. It returns that state's path, index and metric, plus the write pointer of the step that produced it. It replaces the fixed four-state selector, sits between the add-compare-select array and the traceback/output stage, and adds backpressure, a flush control and a renormalisation flag.

## Interface
Parameters:
- NUM_STATES, 4, number of trellis states; power of two, ≥2. LVL = log2(NUM_STATES).
- METRIC_W, 4, width of each accumulated metric.
- PATH_W, 8, width of each survivor path word.
- PTR_W, 3, width of the write pointer carried alongside the data.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- refresh  in  1  synchronous flush of pipeline and outputs.
- valid_in  in  1  input beat valid.
- ready_in  out  1  block can accept a beat this cycle.
- path_in  in  NUM_STATES*PATH_W  survivor paths; state s occupies bits [s*PATH_W +: PATH_W].
- metric_in  in  NUM_STATES*METRIC_W  metrics; state s occupies bits [s*METRIC_W +: METRIC_W].
- write_pointer_in  in  PTR_W  pointer tag travelling with the beat.
- valid_out  out  1  output beat valid.
- ready_out  in  1  downstream accepts the output beat.
- out  out  PATH_W  path of the winning state.
- out_state  out  LVL  index of the winning state.
- out_metric  out  METRIC_W  metric of the winning state.
- write_pointer_out  out  PTR_W  pointer tag of the output beat.
- renorm_req  out  1  MSB of out_metric; qualified by valid_out.

## Operation
- **Comparison tree:** LVL registered levels. Level k holds NUM_STATES>>(k+1) candidates, each candidate being {metric, path, index}. The level-(LVL−1) register is the output register.
- **Pairwise compare:** each pair (even candidate a, odd candidate b) yields a if metric_a <= metric_b, else b.
- **Tie-break:** the lowest state index wins; this follows from the `<=` rule at every level.
- **Arithmetic:** comparisons are unsigned, METRIC_W bits. Metrics pass through unmodified; there is no saturation or subtraction.
- **Per-level sideband:** each level carries a valid bit and the write-pointer tag.
- **Stall:** advance = !valid_out || ready_out. When advance is 0, every level holds its contents, including bubbles; the stall is global.
- **Input acceptance:** ready_in = advance && !refresh. A beat is accepted when valid_in && ready_in.
- **Bubbles:** when valid_in is 0 during an advance, a bubble (valid=0) enters level 0; the data registers of that level may hold stale values.
- **Output transfer:** an output beat transfers when valid_out && ready_out.
- **refresh (synchronous, highest priority after reset):**
  - On the next edge all valid bits clear.
  - Output data returns to its reset values.
  - Any beat presented in the same cycle is dropped; ready_in is 0 during refresh.
  - refresh is not gated by the stall.
- **Reset values** (asynchronous on rst_n low): all valid bits 0, out = 0, out_state = 0, out_metric = all ones, write_pointer_out = 0, renorm_req = 1 (metric MSB is 1, but valid_out = 0 masks it).
- **Mid-operation reset:** in-flight beats are discarded with no output. Normal operation resumes on the first edge after rst_n rises.
- **No internal state:** the block keeps no state across beats beyond the pipeline registers, and performs no accumulation.

## Timing
- **Latency:** LVL cycles from the accepting edge to valid_out, with no stall. NUM_STATES=4 gives 2 cycles; NUM_STATES=8 gives 3.
- **Throughput:** one beat per cycle while ready_out is held high.
- **Holding:** out, out_state, out_metric, write_pointer_out and renorm_req are registered and stay stable while valid_out && !ready_out.
- **Ordering:** beats leave in acceptance order; none are lost or duplicated under any ready_out pattern.
- **Combinational paths:** ready_in depends combinationally on ready_out, valid_out and refresh. No other input-to-output combinational path exists.
- **Priority:** rst_n low, then refresh, then stall. When refresh coincides with an output transfer, the transfer completes and the pipeline then empties.

## Test plan
1. **Minimum at state 0:** NUM_STATES=4, ready_out=1, metrics {s0..s3} = {1,5,7,9}, paths A0,B0,C0,D0, ptr 3. Required 2 cycles later: valid_out=1, out=A0, out_state=0, out_metric=1, write_pointer_out=3.
2. **Back-to-back beats and tie-break:** beats whose minimum sits at state 1 (8,2,6,7), state 2 (9,8,3,7) and state 3 (9,8,7,4), then all metrics equal to 5. Required on consecutive cycles: out_state = 1, 2, 3, 0 with matching paths. Next, metrics {F,F,F,0}: required out_state=3, renorm_req=0. Next, metrics {9,A,B,C}: required renorm_req=1.
3. **Backpressure:** ready_out held low for 4 cycles while 3 beats are offered. Required: ready_in drops after the pipeline fills; the output holds beat 1 unchanged; after release, beats appear in order with none lost.
4. **Refresh:** refresh asserted with one beat in flight and valid_in=1 in the same cycle. Required next cycle: valid_out=0, out=00, out_metric=F; the dropped beat never appears.
5. **Mid-operation reset:** rst_n pulsed low asynchronously between clock edges while the pipeline is full. Required immediately: all outputs at reset values. After release, a new beat emerges after LVL cycles.
6. **Eight states:** NUM_STATES=8, METRIC_W=6, unique minimum metric 3 at state 5. Required after 3 cycles: out_state=5 with that state's path. Then all metrics equal: required out_state=0.
